// File: rtl/sm83_serial_link_if.sv
// CPU bus, serial pins and harness logging signals of the SM83 serial port.
// Writes commit on the WR falling edge using A/D_IN of that cycle. Reads are combinational while MREQ&RD.
interface sm83_serial_link_if;
  logic        MREQ;
  logic        RD;
  logic        WR;
  logic [15:0] A;
  logic [7:0]  D_IN;
  logic [7:0]  D_OUT;
  logic        D_OE;
  logic        SIN;
  logic        SCK_IN;
  logic        SOUT;
  logic        SCK_OUT;
  logic        IRQ;
  logic [7:0]  TX_BYTE;
  logic        TX_STROBE;

  modport slave (
    input  MREQ, RD, WR, A, D_IN, SIN, SCK_IN,
    output D_OUT, D_OE, SOUT, SCK_OUT, IRQ, TX_BYTE, TX_STROBE
  );

  modport master (
    output MREQ, RD, WR, A, D_IN, SIN, SCK_IN,
    input  D_OUT, D_OE, SOUT, SCK_OUT, IRQ, TX_BYTE, TX_STROBE
  );
endinterface

// File: rtl/sm83_serial_link.sv
// SM83 serial port (SB/SC): shifts SB out MSB-first on SOUT while shifting SIN in,
// internally clocked (CLK_DIV per bit) or from a synchronised external SCK_IN.
module sm83_serial_link #(
  parameter logic [15:0] SB_ADDR = 16'hFF01,
  parameter logic [15:0] SC_ADDR = 16'hFF02,
  parameter int          CLK_DIV = 512
) (
  input  logic              CLK,
  input  logic              RESET,
  sm83_serial_link_if.slave bus,
  output logic [1:0]        dbg_state
);
  localparam int HALF = CLK_DIV / 2;
  localparam int CW   = (HALF > 1) ? $clog2(HALF) : 1;

  typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

  state_t        state;
  logic [7:0]    sb;
  logic [7:0]    tx_hold;
  logic [2:0]    bitcnt;
  logic [CW-1:0] cnt;
  logic          busy;
  logic          clk_sel;
  logic          mode_int;
  logic          sout_r;
  logic          sck_r;
  logic          irq_r;
  logic          txs_r;
  logic [7:0]    txb_r;
  logic          wr_q;
  logic          s1, s2, s3;

  logic commit, wr_sb, wr_sc, idle_like, expire, rise, fall;
  logic adv_high, adv_low, adv_done;

  assign commit    = wr_q & ~bus.WR;
  assign wr_sb     = commit & (bus.A == SB_ADDR);
  assign wr_sc     = commit & (bus.A == SC_ADDR);
  assign idle_like = (state == IDLE) || (state == DONE);
  assign expire    = (cnt == '0);
  assign rise      = s2 & ~s3;
  assign fall      = ~s2 & s3;

  // In external mode the last bit completes as soon as its rising edge has shifted.
  assign adv_high = (state == LOW) && (mode_int ? expire : rise);
  assign adv_low  = (state == HIGH) && (bitcnt != 3'd7) && (mode_int ? expire : fall);
  assign adv_done = (state == HIGH) && (bitcnt == 3'd7) && (mode_int ? expire : 1'b1);

  assign bus.D_OE      = bus.MREQ & bus.RD & ((bus.A == SB_ADDR) | (bus.A == SC_ADDR));
  assign bus.D_OUT     = (bus.A == SC_ADDR) ? {busy, 6'b111111, clk_sel} : sb;
  assign bus.SOUT      = sout_r;
  assign bus.SCK_OUT   = sck_r;
  assign bus.IRQ       = irq_r;
  assign bus.TX_STROBE = txs_r;
  assign bus.TX_BYTE   = txb_r;
  assign dbg_state     = state;

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state    <= IDLE;
      sb       <= 8'h00;
      tx_hold  <= 8'h00;
      bitcnt   <= 3'd0;
      cnt      <= '0;
      busy     <= 1'b0;
      clk_sel  <= 1'b0;
      mode_int <= 1'b0;
      sout_r   <= 1'b1;
      sck_r    <= 1'b1;
      irq_r    <= 1'b0;
      txs_r    <= 1'b0;
      txb_r    <= 8'h00;
      wr_q     <= 1'b0;
      s1       <= 1'b1;
      s2       <= 1'b1;
      s3       <= 1'b1;
    end else begin
      wr_q  <= bus.WR;
      s1    <= bus.SCK_IN;
      s2    <= s1;
      s3    <= s2;
      irq_r <= 1'b0;
      txs_r <= 1'b0;
      if (cnt != '0) cnt <= cnt - 1'b1;
      if (wr_sc) clk_sel <= bus.D_IN[0];

      if (idle_like) begin
        // DONE behaves as IDLE for writes, so a start landing on DONE begins the next transfer.
        state <= IDLE;
        if (wr_sb) sb <= bus.D_IN;
        if (wr_sc && bus.D_IN[7]) begin
          state    <= LOW;
          busy     <= 1'b1;
          tx_hold  <= sb;
          bitcnt   <= 3'd0;
          mode_int <= bus.D_IN[0];
          sout_r   <= sb[7];
          sck_r    <= ~bus.D_IN[0];
          cnt      <= CW'(HALF - 1);
        end
      end else if (wr_sc && !bus.D_IN[7]) begin
        state  <= IDLE;
        busy   <= 1'b0;
        sck_r  <= 1'b1;
        sout_r <= 1'b1;
      end else if (adv_high) begin
        state <= HIGH;
        sck_r <= 1'b1;
        sb    <= {sb[6:0], bus.SIN};
        cnt   <= CW'(HALF - 1);
      end else if (adv_low) begin
        state  <= LOW;
        bitcnt <= bitcnt + 3'd1;
        sout_r <= sb[7];
        sck_r  <= ~mode_int;
        cnt    <= CW'(HALF - 1);
      end else if (adv_done) begin
        state <= DONE;
        busy  <= 1'b0;
        irq_r <= 1'b1;
        txs_r <= 1'b1;
        txb_r <= tx_hold;
      end
    end
  end
endmodule
